// File: rtl/mem_ctrl_pkg.sv
// Shared types for the packet-buffer controllers (write side, read side and their benches).
package mem_ctrl_pkg;

  // Controller state machine encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    CLEAR = 2'd3
  } state_t;

  // Framing flags carried alongside each data word. The full entry type
  // {data, sop, eop} is declared where DWIDTH is known.
  typedef struct packed {
    logic sop;
    logic eop;
  } pkt_flags_t;

  // Depth of the output skid FIFO; the read issue rule keeps occupancy below this.
  localparam int FIFO_DEPTH = 2;

  // Stored-packet word count: a zero length field means the buffer is full.
  function automatic int unsigned lenWords(input int unsigned len, input int unsigned awidth);
    return (len == 0) ? (32'd1 << awidth) : len;
  endfunction

endpackage

// File: rtl/pkt_skid_fifo.sv
// Two-entry register FIFO. Slot 0 is always the head; unused slots are kept
// at zero so the head reads as zero whenever the FIFO is empty.
module pkt_skid_fifo #(
  parameter int WIDTH = 18
) (
  input  logic             clk_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]       count_q, count_d;
  logic [1:0]       countAfterPop;

  // Next-state: pop shifts slot 1 forward, then a push lands in the first free slot.
  always_comb begin
    slot0_d       = slot0_q;
    slot1_d       = slot1_q;
    countAfterPop = count_q - {1'b0, pop_i};
    if (pop_i) begin
      slot0_d = slot1_q;
      slot1_d = '0;
    end
    if (push_i) begin
      if (countAfterPop == 2'd0) begin
        slot0_d = data_i;
      end else begin
        slot1_d = data_i;
      end
    end
    count_d = countAfterPop + {1'b0, push_i};
  end

  // Storage registers; flush empties the FIFO and zeroes the slots.
  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head_o  = slot0_q;
  assign count_o = count_q;

endmodule

// File: rtl/mem_rd_ctrl.sv
// Packet buffer read controller: once the write side holds a complete packet,
// read it out of RAM in address order, stream it with sop/eop under ready
// backpressure, then pulse clr_o so the write side can release the buffer.
module mem_rd_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 16
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              busy_i,
  input  logic [AWIDTH-1:0] len_i,
  output logic [AWIDTH-1:0] rdaddr_o,
  output logic              rden_o,
  input  logic [DWIDTH-1:0] rddata_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              val_o,
  output logic              sop_o,
  output logic              eop_o,
  input  logic              ready_i,
  output logic              clr_o
);

  typedef struct packed {
    logic [DWIDTH-1:0] data;
    pkt_flags_t        flags;
  } entry_t;

  localparam int              ENTRY_W = $bits(entry_t);
  localparam logic [AWIDTH:0] IDX_ONE = (AWIDTH + 1)'(1);

  state_t          state_q;
  logic [AWIDTH:0] len_q;
  logic [AWIDTH:0] idx_q;
  logic [AWIDTH:0] lenFull_d;
  logic            inflight_q;
  pkt_flags_t      pendFlags_q;
  pkt_flags_t      issueFlags_d;
  logic            clr_q;

  logic [1:0]      fifoCount;
  entry_t          pushEntry;
  entry_t          headEntry;
  logic            pop;
  logic            lastIdx;
  logic [2:0]      occupancy;

  assign lenFull_d = (AWIDTH + 1)'(lenWords(32'(len_i), AWIDTH));

  // Read issue decision: only read when the word is guaranteed a FIFO slot,
  // counting words already stored, the read in flight, and this cycle's pop.
  always_comb begin
    pop              = val_o & ready_i;
    occupancy        = {1'b0, fifoCount} + {2'b00, inflight_q} - {2'b00, pop};
    rden_o           = (state_q == READ) && (occupancy < 3'(FIFO_DEPTH));
    lastIdx          = (idx_q == (len_q - IDX_ONE));
    issueFlags_d.sop = (idx_q == '0);
    issueFlags_d.eop = lastIdx;
  end

  // Controller FSM plus the one-cycle read pipeline that tracks RAM latency.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q     <= IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      inflight_q  <= 1'b0;
      pendFlags_q <= '0;
      clr_q       <= 1'b0;
    end else begin
      inflight_q  <= rden_o;
      pendFlags_q <= issueFlags_d;
      clr_q       <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (busy_i) begin
            len_q   <= lenFull_d;
            idx_q   <= '0;
            state_q <= READ;
          end
        end
        READ: begin
          if (rden_o) begin
            idx_q <= idx_q + IDX_ONE;
            if (lastIdx) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && eop_o) begin
            clr_q   <= 1'b1;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          idx_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pushEntry = {rddata_i, pendFlags_q};

  pkt_skid_fifo #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk_i  (clk_i),
    .flush_i(srst_i),
    .push_i (inflight_q),
    .data_i (pushEntry),
    .pop_i  (pop),
    .head_o (headEntry),
    .count_o(fifoCount)
  );

  assign val_o    = (fifoCount != 2'd0);
  assign data_o   = headEntry.data;
  assign sop_o    = headEntry.flags.sop;
  assign eop_o    = headEntry.flags.eop;
  assign rdaddr_o = idx_q[AWIDTH-1:0];
  assign clr_o    = clr_q;

endmodule

// File: tb/tb_mem_rd_ctrl.sv
// Scoreboard bench for mem_rd_ctrl: a RAM model with one-cycle read latency,
// expected words queued when a packet is loaded and compared as they appear.
module tb_mem_rd_ctrl;

   localparam int AW     = 4;
   localparam int DW     = 16;
   localparam int NWORDS = 16;

   typedef struct {
      logic [DW-1:0] data;
      logic          sop;
      logic          eop;
   } expWord_t;

   logic          clk_i = 1'b0;
   logic          srst_i;
   logic          busy_i;
   logic [AW-1:0] len_i;
   logic [AW-1:0] rdaddr_o;
   logic          rden_o;
   logic [DW-1:0] rddata_i;
   logic [DW-1:0] data_o;
   logic          val_o;
   logic          sop_o;
   logic          eop_o;
   logic          ready_i;
   logic          clr_o;

   logic [DW-1:0] ram [NWORDS];
   expWord_t      expQ[$];

   int vectors     = 0;
   int miscompares = 0;

   // Owned by the stimulus process.
   int pktLen      = 0;
   int pktStartId  = 0;

   // Owned by the monitor process.
   int seenStartId = 0;
   int readsIssued = 0;
   int expRdAddr   = 0;
   int clrCount    = 0;
   bit prevStall   = 1'b0;
   bit eopAccPrev  = 1'b0;

   mem_rd_ctrl #(
      .AWIDTH(AW),
      .DWIDTH(DW)
   ) dut (
      .clk_i   (clk_i),
      .srst_i  (srst_i),
      .busy_i  (busy_i),
      .len_i   (len_i),
      .rdaddr_o(rdaddr_o),
      .rden_o  (rden_o),
      .rddata_i(rddata_i),
      .data_o  (data_o),
      .val_o   (val_o),
      .sop_o   (sop_o),
      .eop_o   (eop_o),
      .ready_i (ready_i),
      .clr_o   (clr_o)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk_i = ~clk_i;

   // Packet RAM model: data appears exactly one cycle after the read enable.
   always @(posedge clk_i) begin
      if (rden_o) rddata_i <= ram[rdaddr_o];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Monitor on the falling edge: read-address order, clr timing, and the
   // output stream against the scoreboard head (held words are re-checked).
   always @(negedge clk_i) begin
      expWord_t head;
      if (srst_i) begin
         expQ.delete();
         prevStall  = 1'b0;
         eopAccPrev = 1'b0;
      end else begin
         if (pktStartId != seenStartId) begin
            seenStartId = pktStartId;
            readsIssued = 0;
            expRdAddr   = 0;
         end
         if (rden_o) begin
            checkOutput("rd_addr", 32'(rdaddr_o), 32'(expRdAddr % NWORDS));
            checkOutput("rd_in_range", 32'(readsIssued < pktLen), 32'd1);
            expRdAddr++;
            readsIssued++;
         end
         if (clr_o || eopAccPrev) checkOutput("clr", 32'(clr_o), 32'(eopAccPrev));
         if (clr_o) clrCount++;
         eopAccPrev = 1'b0;
         if (prevStall) checkOutput("val_held", 32'(val_o), 32'd1);
         if (val_o) begin
            if (expQ.size() == 0) begin
               checkOutput("extra_word", 32'(val_o), 32'd0);
            end else begin
               head = expQ[0];
               checkOutput("data", 32'(data_o), 32'(head.data));
               checkOutput("sop", 32'(sop_o), 32'(head.sop));
               checkOutput("eop", 32'(eop_o), 32'(head.eop));
               if (ready_i) begin
                  void'(expQ.pop_front());
                  eopAccPrev = head.eop;
               end
            end
         end
         prevStall = val_o && !ready_i;
      end
   end

   // Load a packet into RAM, queue its expected words and raise busy.
   task automatic applyStimulus(input int n, input logic [DW-1:0] base);
      int words;
      words = (n == 0) ? NWORDS : n;
      for (int i = 0; i < words; i++) begin
         ram[i] = base + DW'(i);
         expQ.push_back('{data: base + DW'(i), sop: (i == 0), eop: (i == words - 1)});
      end
      pktLen = words;
      pktStartId++;
      len_i  = AW'(n);
      busy_i = 1'b1;
   endtask

   // Run a packet to its clr pulse with a cycle bound, optionally checking
   // start-up latency or toggling ready 1,0,0,1,...; then drop busy.
   task automatic waitPacketDone(input bit checkTiming, input bit toggleReady);
      int k;
      int clrBefore;
      bit done;
      k         = 0;
      done      = 1'b0;
      clrBefore = clrCount;
      while (!done && k < 200) begin
         @(posedge clk_i);
         #1;
         k++;
         if (toggleReady) ready_i = ((k % 3) == 0);
         if (checkTiming && k == 1) checkOutput("rden_t1", 32'(rden_o), 32'd1);
         if (checkTiming && k == 2) checkOutput("val_t2", 32'(val_o), 32'd0);
         if (checkTiming && k == 3) checkOutput("sop_t3", 32'({val_o, sop_o}), 32'd3);
         if (clr_o) done = 1'b1;
      end
      if (!done) checkOutput("clr_timeout", 32'd0, 32'd1);
      else if (checkTiming) checkOutput("clr_cycle", 32'(k), 32'(pktLen + 3));
      busy_i  = 1'b0;
      ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      checkOutput("clr_count", 32'(clrCount - clrBefore), 32'd1);
      checkOutput("sb_empty", 32'(expQ.size()), 32'd0);
      checkOutput("reads", 32'(readsIssued), 32'(pktLen));
   endtask

   initial begin
      srst_i  = 1'b1;
      busy_i  = 1'b0;
      len_i   = '0;
      ready_i = 1'b1;
      for (int i = 0; i < NWORDS; i++) ram[i] = '0;
      repeat (3) @(posedge clk_i);
      #1;
      checkOutput("rst_rdaddr", 32'(rdaddr_o), 32'd0);
      checkOutput("rst_rden", 32'(rden_o), 32'd0);
      checkOutput("rst_data", 32'(data_o), 32'd0);
      checkOutput("rst_val", 32'(val_o), 32'd0);
      checkOutput("rst_sop", 32'(sop_o), 32'd0);
      checkOutput("rst_eop", 32'(eop_o), 32'd0);
      checkOutput("rst_clr", 32'(clr_o), 32'd0);
      srst_i = 1'b0;
      @(posedge clk_i);
      #1;

      $display("[TB] three-word packet");
      applyStimulus(3, 16'h00A0);
      waitPacketDone(1'b1, 1'b0);

      $display("[TB] single-word packet");
      applyStimulus(1, 16'h00B0);
      waitPacketDone(1'b1, 1'b0);

      $display("[TB] full buffer, len 0");
      applyStimulus(0, 16'h1000);
      waitPacketDone(1'b1, 1'b0);

      $display("[TB] five words with ready toggling");
      applyStimulus(5, 16'h2000);
      waitPacketDone(1'b0, 1'b1);

      $display("[TB] reset on third output word");
      applyStimulus(8, 16'h0300);
      repeat (5) begin
         @(posedge clk_i);
         #1;
      end
      checkOutput("pre_rst_val", 32'(val_o), 32'd1);
      checkOutput("pre_rst_data", 32'(data_o), 32'h0302);
      srst_i = 1'b1;
      @(posedge clk_i);
      #1;
      srst_i = 1'b0;
      busy_i = 1'b0;
      checkOutput("mid_rst_rdaddr", 32'(rdaddr_o), 32'd0);
      checkOutput("mid_rst_rden", 32'(rden_o), 32'd0);
      checkOutput("mid_rst_data", 32'(data_o), 32'd0);
      checkOutput("mid_rst_val", 32'(val_o), 32'd0);
      checkOutput("mid_rst_sop", 32'(sop_o), 32'd0);
      checkOutput("mid_rst_eop", 32'(eop_o), 32'd0);
      checkOutput("mid_rst_clr", 32'(clr_o), 32'd0);
      @(posedge clk_i);
      #1;
      applyStimulus(8, 16'h0400);
      waitPacketDone(1'b1, 1'b0);

      $display("[TB] back-to-back packets");
      applyStimulus(4, 16'h5000);
      waitPacketDone(1'b1, 1'b0);
      applyStimulus(2, 16'h6000);
      waitPacketDone(1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
